// File: rtl/lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: access codes, FSM states, byte-enable masks.
// The misalignment helper is only referenced when MISALIGN_TRAP_EN is defined.
package lsu_pkg;

  typedef enum logic [2:0] {
    LT_LB  = 3'b000,
    LT_LH  = 3'b001,
    LT_LW  = 3'b010,
    LT_LBU = 3'b100,
    LT_LHU = 3'b101
  } load_type_e;

  typedef enum logic [1:0] {
    ST_SB = 2'b00,
    ST_SH = 2'b01,
    ST_SW = 2'b10
  } store_type_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Halfword accesses need addr[0]=0 and word accesses need addr[1:0]=0; byte accesses never trap.
  function automatic logic lsu_misaligned(input logic       is_load,
                                          input logic [2:0] load_type,
                                          input logic [1:0] store_type,
                                          input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (is_load) begin
      case (load_type)
        LT_LH, LT_LHU: mis = addr_lo[0];
        LT_LW:         mis = |addr_lo;
        default:       mis = 1'b0;
      endcase
    end else begin
      case (store_type)
        ST_SB:   mis = 1'b0;
        ST_SH:   mis = addr_lo[0];
        default: mis = |addr_lo;
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/gnt/rvalid bus between the LSU (master) and the memory (slave).
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Load formatter: picks the byte/halfword lane from the read word and sign/zero extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  load_type,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    result = '0;
    case (load_type)
      LT_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LT_LH:   result = {{16{half_sel[15]}}, half_sel};
      LT_LW:   result = rdata;
      LT_LBU:  result = {24'h0, byte_sel};
      LT_LHU:  result = {16'h0, half_sel};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one data-memory access per memory instruction and stalls upstream until done.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of wrapping within the word.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            alu_result_mem,
  input  logic [31:0]            rs2_data_mem,
  input  logic                   mem_read_mem,
  input  logic                   mem_write_mem,
  input  logic [2:0]             mem_load_type_mem,
  input  logic [1:0]             mem_store_type_mem,
  input  logic                   memtoreg_mem,
  mem_stage_lsu_if.master        dmem,
  output logic                   stall_mem,
  output logic [31:0]            wb_data_mem,
  output logic                   bus_err_mem,
  output logic                   misalign_exc_mem
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  lsu_state_e       state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [31:0]      load_data_r;
  logic [1:0]       addr_lo_r;
  logic [2:0]       load_type_r;

  logic             access;
  logic             misalign;
  logic             tmo_hit;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [31:0]      load_fmt;

  assign access = mem_read_mem | mem_write_mem;

`ifdef MISALIGN_TRAP_EN
  assign misalign = access & lsu_misaligned(mem_read_mem, mem_load_type_mem,
                                            mem_store_type_mem, alu_result_mem[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // Counter holds the number of REQ/WAIT cycles already spent; the last allowed cycle is TIMEOUT_CYCLES-1.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    st_be    = BE_WORD;
    st_wdata = rs2_data_mem;
    case (mem_store_type_mem)
      ST_SB: begin
        st_be    = BE_BYTE << alu_result_mem[1:0];
        st_wdata = {4{rs2_data_mem[7:0]}};
      end
      ST_SH: begin
        st_be    = BE_HALF << {alu_result_mem[1], 1'b0};
        st_wdata = {2{rs2_data_mem[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_load_align u_load_align (
    .rdata     (dmem.dmem_rdata),
    .addr_lo   (addr_lo_r),
    .load_type (load_type_r),
    .result    (load_fmt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      dmem.dmem_req    <= 1'b0;
      dmem.dmem_we     <= 1'b0;
      dmem.dmem_addr   <= '0;
      dmem.dmem_be     <= '0;
      dmem.dmem_wdata  <= '0;
      load_data_r      <= '0;
      tmo_cnt          <= '0;
      addr_lo_r        <= '0;
      load_type_r      <= '0;
      bus_err_mem      <= 1'b0;
      misalign_exc_mem <= 1'b0;
    end else begin
      bus_err_mem      <= 1'b0;
      misalign_exc_mem <= 1'b0;
      case (state)
        IDLE: begin
          if (misalign) begin
            misalign_exc_mem <= 1'b1;
            state            <= DONE;
          end else if (access) begin
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= ~mem_read_mem;
            dmem.dmem_addr  <= {alu_result_mem[31:2], 2'b00};
            dmem.dmem_be    <= mem_read_mem ? BE_WORD : st_be;
            dmem.dmem_wdata <= st_wdata;
            addr_lo_r       <= alu_result_mem[1:0];
            load_type_r     <= mem_load_type_mem;
            tmo_cnt         <= '0;
            state           <= REQ;
          end
        end
        REQ: begin
          if (tmo_hit) begin
            dmem.dmem_req <= 1'b0;
            bus_err_mem   <= 1'b1;
            load_data_r   <= '0;
            state         <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (dmem.dmem_gnt) begin
              dmem.dmem_req <= 1'b0;
              state         <= WAIT;
            end
          end
        end
        WAIT: begin
          if (tmo_hit) begin
            bus_err_mem <= 1'b1;
            load_data_r <= '0;
            state       <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (dmem.dmem_rvalid) begin
              if (!dmem.dmem_we) load_data_r <= load_fmt;
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_mem   = ((state == IDLE) && access && !misalign) || (state == REQ) || (state == WAIT);
  assign wb_data_mem = memtoreg_mem ? load_data_r : alu_result_mem;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu against a behavioural model of the LSU access and formatting rules.
`timescale 1ns/1ps
module tb_mem_stage_lsu;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_mem, rs2_data_mem;
  logic        mem_read_mem, mem_write_mem, memtoreg_mem;
  logic [2:0]  mem_load_type_mem;
  logic [1:0]  mem_store_type_mem;
  logic        stall_mem, bus_err_mem, misalign_exc_mem;
  logic [31:0] wb_data_mem;

  mem_stage_lsu_if dmem_if();

  mem_stage_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                (clk),
    .rst                (rst),
    .alu_result_mem     (alu_result_mem),
    .rs2_data_mem       (rs2_data_mem),
    .mem_read_mem       (mem_read_mem),
    .mem_write_mem      (mem_write_mem),
    .mem_load_type_mem  (mem_load_type_mem),
    .mem_store_type_mem (mem_store_type_mem),
    .memtoreg_mem       (memtoreg_mem),
    .dmem               (dmem_if),
    .stall_mem          (stall_mem),
    .wb_data_mem        (wb_data_mem),
    .bus_err_mem        (bus_err_mem),
    .misalign_exc_mem   (misalign_exc_mem)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model_ld = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] lt);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (lt)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input bit ld, input logic [31:0] a, input logic [1:0] st);
    if (ld || st >= 2) return 4'hF;
    if (st == 0) return 4'(1 << (a % 4));
    return 4'(3 << (2 * ((a / 2) % 2)));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [1:0] st);
    if (st == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (st == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // kind: 0 non-memory, 1 load, 2 store, 3 load+store (load wins). gd=0 means gnt never comes.
  // Called and returns at a falling edge.
  task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [2:0] lt, input logic [1:0] st, input logic m2r,
                         input logic [31:0] rword, input int gd, input int rd);
    bit is_ld, is_mem, exp_tmo, granted, done;
    int stalls, reqn, waitn, exp_stalls;
    is_ld  = (kind == 1) || (kind == 3);
    is_mem = (kind != 0);
    exp_tmo = is_mem && (gd == 0);
    exp_stalls = !is_mem ? 0 : (exp_tmo ? 1 + int'(TMO) : 1 + gd + rd);

    alu_result_mem     = addr;
    rs2_data_mem       = rs2;
    mem_read_mem       = is_ld;
    mem_write_mem      = (kind >= 2);
    mem_load_type_mem  = lt;
    mem_store_type_mem = st;
    memtoreg_mem       = m2r;
    dmem_if.dmem_gnt    = 1'b0;
    dmem_if.dmem_rvalid = 1'b0;

    stalls = 0; reqn = 0; waitn = 0; granted = 0; done = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!stall_mem) begin
        done = 1;
        break;
      end
      stalls++;
      dmem_if.dmem_gnt    = 1'b0;
      dmem_if.dmem_rvalid = 1'b0;
      dmem_if.dmem_rdata  = $urandom;
      if (dmem_if.dmem_req) begin
        reqn++;
        check_val("req_addr", dmem_if.dmem_addr, addr & 32'hFFFF_FFFC);
        check_val("req_be", {28'h0, dmem_if.dmem_be}, {28'h0, ref_be(is_ld, addr, st)});
        check_val("req_we", {31'h0, dmem_if.dmem_we}, {31'h0, !is_ld});
        if (!is_ld) check_val("req_wdata", dmem_if.dmem_wdata, ref_wdata(rs2, st));
        // Responses without a prior grant must be ignored.
        dmem_if.dmem_rvalid = 1'($urandom_range(0, 1));
        if (reqn == gd) begin
          dmem_if.dmem_gnt = 1'b1;
          granted = 1;
        end
      end else if (granted) begin
        waitn++;
        if (waitn == rd) begin
          dmem_if.dmem_rvalid = 1'b1;
          dmem_if.dmem_rdata  = rword;
        end
      end
      @(negedge clk);
    end

    check_val("done_reached", {31'h0, done}, 32'd1);
    check_val("stall_cycles", stalls, exp_stalls);
    if (exp_tmo) model_ld = '0;
    else if (is_ld) model_ld = ref_load(rword, addr, lt);
    check_val("wb_data", wb_data_mem, m2r ? model_ld : addr);
    check_val("bus_err", {31'h0, bus_err_mem}, {31'h0, exp_tmo});
    check_val("req_done", {31'h0, dmem_if.dmem_req}, 32'd0);
    check_val("misalign", {31'h0, misalign_exc_mem}, 32'd0);

    dmem_if.dmem_gnt    = 1'b0;
    dmem_if.dmem_rvalid = 1'b0;
    mem_read_mem        = 1'b0;
    mem_write_mem       = 1'b0;
    @(negedge clk);
    #1;
    if (exp_tmo) check_val("bus_err_pulse_end", {31'h0, bus_err_mem}, 32'd0);
    check_val("idle_stall", {31'h0, stall_mem}, 32'd0);
    @(negedge clk);
  endtask

  // Reset while a load is outstanding: in_req=1 hits it in REQ, otherwise in WAIT.
  task automatic reset_mid(input bit in_req);
    alu_result_mem    = 32'h0000_0040;
    mem_read_mem      = 1'b1;
    mem_write_mem     = 1'b0;
    mem_load_type_mem = 3'd2;
    memtoreg_mem      = 1'b1;
    @(negedge clk);
    check_val("rst_req_up", {31'h0, dmem_if.dmem_req}, 32'd1);
    if (!in_req) begin
      dmem_if.dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_if.dmem_gnt = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check_val("rst_req", {31'h0, dmem_if.dmem_req}, 32'd0);
    check_val("rst_addr", dmem_if.dmem_addr, 32'h0);
    check_val("rst_be", {28'h0, dmem_if.dmem_be}, 32'h0);
    mem_read_mem = 1'b0;
    model_ld = '0;
    @(negedge clk);
    rst = 1'b0;
    dmem_if.dmem_rvalid = 1'b1;
    dmem_if.dmem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem_if.dmem_rvalid = 1'b0;
    #1;
    check_val("rst_wb", wb_data_mem, model_ld);
    check_val("rst_stall", {31'h0, stall_mem}, 32'd0);
    check_val("rst_req_after", {31'h0, dmem_if.dmem_req}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int kind, gd;
    rst = 1'b1;
    alu_result_mem = '0; rs2_data_mem = '0;
    mem_read_mem = 1'b0; mem_write_mem = 1'b0; memtoreg_mem = 1'b1;
    mem_load_type_mem = '0; mem_store_type_mem = '0;
    dmem_if.dmem_gnt = 1'b0; dmem_if.dmem_rvalid = 1'b0; dmem_if.dmem_rdata = '0;

    repeat (2) @(negedge clk);
    #1;
    check_val("reset_req", {31'h0, dmem_if.dmem_req}, 32'd0);
    check_val("reset_we", {31'h0, dmem_if.dmem_we}, 32'd0);
    check_val("reset_addr", dmem_if.dmem_addr, 32'h0);
    check_val("reset_be", {28'h0, dmem_if.dmem_be}, 32'h0);
    check_val("reset_wdata", dmem_if.dmem_wdata, 32'h0);
    check_val("reset_bus_err", {31'h0, bus_err_mem}, 32'd0);
    check_val("reset_misalign", {31'h0, misalign_exc_mem}, 32'd0);
    check_val("reset_stall", {31'h0, stall_mem}, 32'd0);
    check_val("reset_wb", wb_data_mem, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_txn(1, 32'h0000_1003, 32'h0, 3'd0, 2'd0, 1'b1, 32'h80FF_1234, 1, 1);
    run_txn(2, 32'h0000_2002, 32'h0000_BEEF, 3'd0, 2'd1, 1'b0, 32'h0, 1, 1);
    run_txn(1, 32'h0000_0002, 32'h0, 3'd5, 2'd0, 1'b1, 32'h8001_0000, 4, 1);
    run_txn(0, 32'h1234_5678, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0, 1, 1);
    run_txn(1, 32'h0000_0100, 32'h0, 3'd2, 2'd0, 1'b1, 32'h0, 0, 1);
    run_txn(2, 32'h0000_0201, 32'hA5C3_7E19, 3'd0, 2'd3, 1'b1, 32'h0, 2, 3);
    reset_mid(1'b0);
    reset_mid(1'b1);
    run_txn(1, 32'h0000_3001, 32'h0, 3'd1, 2'd0, 1'b1, 32'h1234_F00D, 1, 2);

    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 3);
      gd = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      run_txn(kind, $urandom, $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom, gd, $urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
